regfile_mp: RTL and testbench

//   Parametrised multi-port register file for the MIPS-style datapath; successor to the

---
 rtl/regfile_mp.sv | 108 ++++++++++
 tb/tb_regfile_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: N_RD combinational read ports, two write ports (port 1 wins), busy scoreboard.
// Latency: reads 0 cycles (optional same-cycle write bypass), writes/scoreboard commit on the next rising edge.
// Backpressure: none; every write, reserve and read is accepted in the cycle it is presented.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  output logic [N_RD-1:0]          rbusy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr0_ok;
  logic              w_wr1_ok;

  // A write to register 0 is suppressed when it is hardwired to zero.
  assign w_wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Scoreboard next state: a new reservation beats a completing write on the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((we0 && (waddr0 == ADDR_W'(i))) || (we1 && (waddr1 == ADDR_W'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Array and scoreboard update; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0_ok) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_wr1_ok) begin
        r_mem[waddr1] <= wdata1;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  genvar k;
  generate
    for (k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rb;

      assign w_ra = raddr[k*ADDR_W +: ADDR_W];

      // Read mux: array contents, overridden by a same-cycle write when bypass is enabled.
      always_comb begin
        w_rd = r_mem[w_ra];
        w_rb = r_busy[w_ra];
        if (BYPASS != 0) begin
          if (w_wr0_ok && (waddr0 == w_ra)) begin
            w_rd = wdata0;
            w_rb = rsv_en && (rsv_addr == w_ra);
          end
          if (w_wr1_ok && (waddr1 == w_ra)) begin
            w_rd = wdata1;
            w_rb = rsv_en && (rsv_addr == w_ra);
          end
        end
        if ((ZERO_REG != 0) && (w_ra == '0)) begin
          w_rd = '0;
          w_rb = 1'b0;
        end
      end

      assign rdata[k*DATA_W +: DATA_W] = w_rd;
      assign rbusy[k]                  = w_rb;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for per-cycle behaviour, hand sequences for reset and no-bypass.
// Latency: outputs sampled mid-cycle, 4 time units after the driving edge.
// Backpressure: not applicable.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we0, we1, rsv_en;
  logic [4:0]  waddr0, waddr1, rsv_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [31:0] busy_vec, busy_vec_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb), .busy_vec(busy_vec_nb)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        b0;
    logic        b1;
    logic [31:0] ebv;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic rs, logic [4:0] ra, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] e0, logic [31:0] e1, logic b0, logic b1,
                              logic [31:0] ebv);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.rsv = rs; v.ra = ra; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.e1 = e1; v.b0 = b0; v.b1 = b1; v.ebv = ebv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Read all 32 registers through both ports on both instances and expect zero and idle.
  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("%s_rd0_r%0d", tag, i), rdata[31:0], 32'h0);
      chk($sformatf("%s_rd1_r%0d", tag, 31 - i), rdata[63:32], 32'h0);
      chk($sformatf("%s_nb_rd0_r%0d", tag, i), rdata_nb[31:0], 32'h0);
      chk($sformatf("%s_rb_r%0d", tag, i), {30'h0, rbusy}, 32'h0);
    end
    chk({tag, "_busy_vec"}, busy_vec, 32'h0);
    chk({tag, "_nb_busy_vec"}, busy_vec_nb, 32'h0);
  endtask

  initial begin
    //            we0 wa0 wd0           we1 wa1 wd1     rsv ra  r0  r1  e0            e1            b0 b1 ebv
    vecs[0]  = mk(1, 5,  32'hDEAD_BEEF, 0, 0,  0,       0, 0,  5,  5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0,  0,             0, 0,  0,       0, 0,  5,  0,  32'hDEAD_BEEF, 32'h0,         0, 0, 32'h0);
    vecs[2]  = mk(1, 7,  32'h1,         1, 7,  32'h2,   0, 0,  7,  5,  32'h2,         32'hDEAD_BEEF, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0,  0,             0, 0,  0,       0, 0,  7,  7,  32'h2,         32'h2,         0, 0, 32'h0);
    vecs[4]  = mk(0, 0,  0,             1, 0,  32'h1234, 1, 0, 0,  3,  32'h0,         32'h0,         0, 0, 32'h0);
    vecs[5]  = mk(0, 0,  0,             0, 0,  0,       0, 0,  0,  0,  32'h0,         32'h0,         0, 0, 32'h0);
    vecs[6]  = mk(0, 0,  0,             0, 0,  0,       1, 9,  9,  9,  32'h0,         32'h0,         0, 0, 32'h0);
    vecs[7]  = mk(0, 0,  0,             0, 0,  0,       0, 0,  9,  9,  32'h0,         32'h0,         1, 1, 32'h0000_0200);
    vecs[8]  = mk(1, 9,  32'hAA,        0, 0,  0,       1, 9,  9,  5,  32'hAA,        32'hDEAD_BEEF, 1, 0, 32'h0000_0200);
    vecs[9]  = mk(0, 0,  0,             0, 0,  0,       0, 0,  9,  5,  32'hAA,        32'hDEAD_BEEF, 1, 0, 32'h0000_0200);
    vecs[10] = mk(1, 9,  32'hBB,        0, 0,  0,       0, 0,  9,  9,  32'hBB,        32'hBB,        0, 0, 32'h0000_0200);
    vecs[11] = mk(0, 0,  0,             0, 0,  0,       0, 0,  9,  7,  32'hBB,        32'h2,         0, 0, 32'h0);
    vecs[12] = mk(0, 0,  0,             1, 31, 32'h5555, 1, 12, 31, 12, 32'h5555,     32'h0,         0, 0, 32'h0);
    vecs[13] = mk(0, 0,  0,             0, 0,  0,       0, 0,  31, 12, 32'h5555,      32'h0,         0, 1, 32'h0000_1000);
    vecs[14] = mk(1, 12, 32'h77,        0, 0,  0,       0, 0,  12, 12, 32'h77,        32'h77,        0, 0, 32'h0000_1000);
    vecs[15] = mk(0, 0,  0,             0, 0,  0,       0, 0,  12, 31, 32'h77,        32'h5555,      0, 0, 32'h0);
    vecs[16] = mk(1, 3,  32'h33,        1, 4,  32'h44,  0, 0,  3,  4,  32'h33,        32'h44,        0, 0, 32'h0);
    vecs[17] = mk(0, 0,  0,             0, 0,  0,       0, 0,  3,  4,  32'h33,        32'h44,        0, 0, 32'h0);

    idle();
    raddr   = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_all_zero("init");

    // Table: drive just after an edge, sample mid-cycle, let the next edge commit.
    for (int n = 0; n < NV; n++) begin
      @(posedge clk);
      #1;
      we0 = vecs[n].we0; waddr0 = vecs[n].wa0; wdata0 = vecs[n].wd0;
      we1 = vecs[n].we1; waddr1 = vecs[n].wa1; wdata1 = vecs[n].wd1;
      rsv_en = vecs[n].rsv; rsv_addr = vecs[n].ra;
      raddr = {vecs[n].r1, vecs[n].r0};
      #3;
      chk($sformatf("v%0d_rd0", n), rdata[31:0], vecs[n].e0);
      chk($sformatf("v%0d_rd1", n), rdata[63:32], vecs[n].e1);
      chk($sformatf("v%0d_rb0", n), {31'h0, rbusy[0]}, {31'h0, vecs[n].b0});
      chk($sformatf("v%0d_rb1", n), {31'h0, rbusy[1]}, {31'h0, vecs[n].b1});
      chk($sformatf("v%0d_busy_vec", n), busy_vec, vecs[n].ebv);
    end

    // No-bypass instance returns the old value during the write cycle, new value after the edge.
    @(posedge clk);
    #1;
    idle();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0BAD_F00D;
    raddr = {5'd7, 5'd5};
    #3;
    chk("nb_write_cycle_rd0", rdata_nb[31:0], 32'hDEAD_BEEF);
    chk("byp_write_cycle_rd0", rdata[31:0], 32'h0BAD_F00D);
    chk("nb_reg7_rd1", rdata_nb[63:32], 32'h2);
    @(posedge clk);
    #1;
    idle();
    #3;
    chk("nb_after_edge_rd0", rdata_nb[31:0], 32'h0BAD_F00D);

    // Scattered writes and reservations, then a reservation followed by reset.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      we0 = 1'b1; waddr0 = 5'($urandom_range(1, 31)); wdata0 = $urandom;
      we1 = 1'b1; waddr1 = 5'($urandom_range(1, 31)); wdata1 = $urandom | 32'h1;
      rsv_en = 1'b1; rsv_addr = 5'($urandom_range(1, 31));
    end
    @(posedge clk);
    #1;
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    @(posedge clk);
    #1;
    idle();
    raddr = {5'd3, 5'd3};
    #1;
    chk("rsv3_busy_bit", {31'h0, busy_vec[3]}, 32'h1);
    chk("rsv3_rbusy0", {31'h0, rbusy[0]}, 32'h1);
    reset_n = 1'b0;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    chk_all_zero("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
